mouse_cmd_sequencer: RTL
========================

Name: mouse_cmd_sequencer

Overview:
PS/2 mouse configuration controller that sits between the host-side byte transmitter/receiver pair and the streaming packet decoder.
- After reset (or on START), issues the mouse init command sequence byte by byte and checks every acknowledge.
- Retries the whole sequence on error or timeout, then reports CFG_DONE or CFG_ERROR.
- The packet decoder is gated by CFG_DONE and takes over the receiver only after configuration completes.

Parameters:
SAMPLE_RATE, 8'd100, argument byte sent after 0xF3 (samples/s)
RESOLUTION, 8'd2, argument byte sent after 0xE8 (2 = 4 counts/mm)
TIMEOUT_CYCLES, 24'd10_000_000, max CLK cycles spent in any wait state (100 ms @ 100 MHz)
MAX_RETRY, 2'd3, full-sequence attempts before declaring failure

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
START  in  1  one-cycle pulse; restarts configuration when in DONE or FAIL
SEND_BYTE  out  1  one-cycle request to transmitter
BYTE_TO_SEND  out  8  command/argument byte, held stable from SEND until BYTE_SENT
BYTE_SENT  in  1  transmitter completion pulse
READ_ENABLE  out  1  receiver enable, high only in WAIT_RESP
BYTE_READ  in  8  received byte
BYTE_ERROR_CODE  in  2  receiver error; nonzero = parity/framing fault
BYTE_READY  in  1  receiver byte-valid pulse
CFG_DONE  out  1  configuration complete, mouse streaming enabled
CFG_ERROR  out  1  sequence failed MAX_RETRY times
RETRY_COUNT  out  2  attempts consumed in current run
STEP  out  4  current step index (debug)

Behaviour:
- Reset values (async assert): state IDLE, all outputs 0, BYTE_TO_SEND 0x00, STEP 0, timeout counter 0. The first cycle after deassert goes IDLE->SEND (auto-start).
- Step table (cmd byte / expected responses, in order):
  - 0: 0xFF / FA, AA, 00
  - 1: 0xF3 / FA
  - 2: SAMPLE_RATE / FA
  - 3: 0xE8 / FA
  - 4: RESOLUTION / FA
  - 5: 0xF4 / FA
- States and transitions:
  - SEND: SEND_BYTE=1 for exactly one cycle, load BYTE_TO_SEND -> WAIT_SENT.
  - WAIT_SENT: on BYTE_SENT -> WAIT_RESP, response index 0.
  - WAIT_RESP: READ_ENABLE=1. On BYTE_READY, compare BYTE_READ with the expected byte and require BYTE_ERROR_CODE==0.
    - Match with more responses pending: stay, index+1.
    - Match on last response: -> NEXT.
    - Mismatch or error: -> RETRY.
  - NEXT: STEP==5 -> DONE; else STEP+1 -> SEND.
  - RETRY: RETRY_COUNT+1; if the new count == MAX_RETRY -> FAIL; else STEP=0 -> SEND (whole sequence restarts).
  - DONE: CFG_DONE=1, READ_ENABLE=0.
  - FAIL: CFG_ERROR=1.
- Timeout: counter clears on entry to WAIT_SENT/WAIT_RESP and on every accepted byte. Reaching TIMEOUT_CYCLES-1 -> RETRY.
- Latency: minimum 3 cycles from BYTE_READY of a final FA to the next SEND_BYTE.
- A 0xFE (resend) response counts as a mismatch; it is not resent individually.
- START in DONE/FAIL: clear CFG_DONE, CFG_ERROR, RETRY_COUNT and STEP, go to SEND. START in any other state is ignored.
- Simultaneous BYTE_READY and timeout terminal count: BYTE_READY wins.
- BYTE_READY outside WAIT_RESP is ignored.
- RESET mid-sequence aborts immediately. BYTE_TO_SEND and SEND_BYTE clear and the run starts over.

Optional Feature:
MOUSE_CMD_INTELLIMOUSE_EN.
- Defined: steps 6-12 inserted after step 0, before 0xF3/SAMPLE_RATE:
  - F3 C8, F3 64, F3 50, each byte expecting FA.
  - Then 0xF2 expecting FA followed by an ID byte.
  - ID 0x03 sets output WHEEL_EN (1 bit, reset 0). Any other ID is accepted and leaves WHEEL_EN=0.
  - STEP then indexes the extended table.
- Undefined: WHEEL_EN port absent, six-step table only.

Test Plan:
- Release RESET, bench model ACKs everything (FA / FA AA 00) -> SEND_BYTE pulses carry FF, F3, 64, E8, 02, F4 in order; CFG_DONE=1, RETRY_COUNT=0.
- Reply FE to the first 0xE8 -> RETRY_COUNT=1, sequence restarts at 0xFF, later reaches CFG_DONE=1.
- Model never asserts BYTE_READY after 0xFF with TIMEOUT_CYCLES=1000 -> RETRY at cycle 1000 of each wait; after 3 attempts CFG_ERROR=1, CFG_DONE=0.
- BYTE_ERROR_CODE=2'b01 with BYTE_READ=FA on the 0xF4 ack -> treated as mismatch, RETRY_COUNT increments.
- In FAIL, pulse START with a healthy model -> flags clear, RETRY_COUNT=0, CFG_DONE=1 after full sequence. START pulsed mid-sequence -> no effect.
- Assert RESET during WAIT_RESP of step 3 -> all outputs 0 within the same cycle; after release the sequence restarts at 0xFF.

Source files
------------

// File: rtl/mouse_cmd_sequencer_if.sv
// Host-side bus of the PS/2 mouse configuration sequencer: transmitter/receiver handshakes and status.
// WHEEL_EN exists only when MOUSE_CMD_INTELLIMOUSE_EN is defined.
`timescale 1ns/1ps
interface mouse_cmd_sequencer_if;
  logic       START;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;
  logic       CFG_DONE;
  logic       CFG_ERROR;
  logic [1:0] RETRY_COUNT;
  logic [3:0] STEP;
`ifdef MOUSE_CMD_INTELLIMOUSE_EN
  logic       WHEEL_EN;
`endif

  modport master (
    input  START, BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY,
    output SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, CFG_DONE, CFG_ERROR, RETRY_COUNT, STEP
`ifdef MOUSE_CMD_INTELLIMOUSE_EN
    , output WHEEL_EN
`endif
  );

  modport slave (
    output START, BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY,
    input  SEND_BYTE, BYTE_TO_SEND, READ_ENABLE, CFG_DONE, CFG_ERROR, RETRY_COUNT, STEP
`ifdef MOUSE_CMD_INTELLIMOUSE_EN
    , input WHEEL_EN
`endif
  );
endinterface

// File: rtl/mouse_cmd_sequencer.sv
// PS/2 mouse init sequencer: sends the command table, checks every acknowledge, retries whole runs.
// Define MOUSE_CMD_INTELLIMOUSE_EN to insert the wheel-detect knock sequence (steps 6-12) and WHEEL_EN.
`timescale 1ns/1ps
module mouse_cmd_sequencer #(
  parameter logic [7:0]  SAMPLE_RATE    = 8'd100,
  parameter logic [7:0]  RESOLUTION     = 8'd2,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000,
  parameter logic [1:0]  MAX_RETRY      = 2'd3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  mouse_cmd_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT_SENT, S_WAIT_RESP, S_NEXT, S_RETRY, S_DONE, S_FAIL
  } state_t;

  localparam logic [3:0] LAST_STEP = 4'd5;

  state_t      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  retry_q, retry_d;
  logic [23:0] tmo_q, tmo_d;
  logic        send_q, send_d;
  logic [7:0]  txb_q, txb_d;
  logic        tmo_hit;
  logic        rx_ok;
`ifdef MOUSE_CMD_INTELLIMOUSE_EN
  logic        wheel_q, wheel_d;
`endif

  function automatic logic [7:0] cmd_byte(input logic [3:0] step);
    case (step)
      4'd0:    return 8'hFF;
      4'd1:    return 8'hF3;
      4'd2:    return SAMPLE_RATE;
      4'd3:    return 8'hE8;
      4'd4:    return RESOLUTION;
      4'd5:    return 8'hF4;
`ifdef MOUSE_CMD_INTELLIMOUSE_EN
      4'd6:    return 8'hF3;
      4'd7:    return 8'hC8;
      4'd8:    return 8'hF3;
      4'd9:    return 8'h64;
      4'd10:   return 8'hF3;
      4'd11:   return 8'h50;
      4'd12:   return 8'hF2;
`endif
      default: return 8'h00;
    endcase
  endfunction

  // Index of the final response byte for a step (reset reply is FA AA 00, get-ID is FA id).
  function automatic logic [1:0] last_idx(input logic [3:0] step);
    if (step == 4'd0) return 2'd2;
`ifdef MOUSE_CMD_INTELLIMOUSE_EN
    if (step == 4'd12) return 2'd1;
`endif
    return 2'd0;
  endfunction

  function automatic logic resp_ok(input logic [3:0] step, input logic [1:0] idx,
                                   input logic [7:0] rx);
    if (step == 4'd0) begin
      case (idx)
        2'd0:    return rx == 8'hFA;
        2'd1:    return rx == 8'hAA;
        2'd2:    return rx == 8'h00;
        default: return 1'b0;
      endcase
    end
`ifdef MOUSE_CMD_INTELLIMOUSE_EN
    if (step == 4'd12 && idx == 2'd1) return 1'b1;
`endif
    return rx == 8'hFA;
  endfunction

  // The knock sequence sits between the reset step and the sample-rate step.
  function automatic logic [3:0] next_step(input logic [3:0] step);
`ifdef MOUSE_CMD_INTELLIMOUSE_EN
    if (step == 4'd0)  return 4'd6;
    if (step == 4'd12) return 4'd1;
`endif
    return step + 4'd1;
  endfunction

  assign tmo_hit = (tmo_q == TIMEOUT_CYCLES - 24'd1);
  assign rx_ok   = (bus.BYTE_ERROR_CODE == 2'b00) && resp_ok(step_q, idx_q, bus.BYTE_READ);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    tmo_d   = tmo_q;
    send_d  = 1'b0;
    txb_d   = txb_q;
`ifdef MOUSE_CMD_INTELLIMOUSE_EN
    wheel_d = wheel_q;
`endif
    case (state_q)
      S_IDLE: state_d = S_SEND;
      S_SEND: begin
        send_d  = 1'b1;
        txb_d   = cmd_byte(step_q);
        tmo_d   = '0;
        state_d = S_WAIT_SENT;
      end
      S_WAIT_SENT: begin
        if (bus.BYTE_SENT) begin
          idx_d   = '0;
          tmo_d   = '0;
          state_d = S_WAIT_RESP;
        end else if (tmo_hit) begin
          state_d = S_RETRY;
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
      end
      // A received byte takes priority over a coincident timeout.
      S_WAIT_RESP: begin
        if (bus.BYTE_READY) begin
          tmo_d = '0;
          if (!rx_ok) begin
            state_d = S_RETRY;
          end else if (idx_q == last_idx(step_q)) begin
`ifdef MOUSE_CMD_INTELLIMOUSE_EN
            if (step_q == 4'd12) wheel_d = (bus.BYTE_READ == 8'h03);
`endif
            state_d = S_NEXT;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else if (tmo_hit) begin
          state_d = S_RETRY;
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
      end
      S_NEXT: begin
        if (step_q == LAST_STEP) begin
          state_d = S_DONE;
        end else begin
          step_d  = next_step(step_q);
          state_d = S_SEND;
        end
      end
      S_RETRY: begin
        retry_d = retry_q + 2'd1;
        if (retry_d == MAX_RETRY) begin
          state_d = S_FAIL;
        end else begin
          step_d  = '0;
          state_d = S_SEND;
        end
      end
      S_DONE, S_FAIL: begin
        if (bus.START) begin
          retry_d = '0;
          step_d  = '0;
`ifdef MOUSE_CMD_INTELLIMOUSE_EN
          wheel_d = 1'b0;
`endif
          state_d = S_SEND;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      idx_q   <= '0;
      retry_q <= '0;
      tmo_q   <= '0;
      send_q  <= 1'b0;
      txb_q   <= '0;
`ifdef MOUSE_CMD_INTELLIMOUSE_EN
      wheel_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
      send_q  <= send_d;
      txb_q   <= txb_d;
`ifdef MOUSE_CMD_INTELLIMOUSE_EN
      wheel_q <= wheel_d;
`endif
    end
  end

  assign bus.SEND_BYTE    = send_q;
  assign bus.BYTE_TO_SEND = txb_q;
  assign bus.READ_ENABLE  = (state_q == S_WAIT_RESP);
  assign bus.CFG_DONE     = (state_q == S_DONE);
  assign bus.CFG_ERROR    = (state_q == S_FAIL);
  assign bus.RETRY_COUNT  = retry_q;
  assign bus.STEP         = step_q;
`ifdef MOUSE_CMD_INTELLIMOUSE_EN
  assign bus.WHEEL_EN     = wheel_q;
`endif

endmodule
